// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared encodings and helpers for the synchronous up/down counter.
//   DIR_UP / DIR_DN     : encodings of the up_dn input
//   MODE_WRAP / MODE_SAT: encodings of the sat input
//   step_act_e          : what a prescaler tick does to the counter value
//   step_action()       : picks the step action from direction, mode and bounds
//   is_boundary()       : true when a tick in this direction hits the bound
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [2:0] {
        ACT_HOLD    = 3'd0,
        ACT_INC     = 3'd1,
        ACT_DEC     = 3'd2,
        ACT_TO_ZERO = 3'd3,
        ACT_TO_MAX  = 3'd4
    } step_act_e;

    // A tick sitting on the bound in the current direction either wraps to
    // the opposite end or holds, depending on the boundary mode.
    function automatic step_act_e step_action(
        input logic up_dn,
        input logic sat,
        input logic at_max,
        input logic at_zero
    );
        step_act_e act;
        act = ACT_HOLD;
        if (up_dn == DIR_UP) begin
            if (!at_max)
                act = ACT_INC;
            else if (sat == MODE_WRAP)
                act = ACT_TO_ZERO;
            else
                act = ACT_HOLD;
        end else begin
            if (!at_zero)
                act = ACT_DEC;
            else if (sat == MODE_WRAP)
                act = ACT_TO_MAX;
            else
                act = ACT_HOLD;
        end
        return act;
    endfunction

    function automatic logic is_boundary(
        input logic up_dn,
        input logic at_max,
        input logic at_zero
    );
        return (up_dn == DIR_UP) ? at_max : at_zero;
    endfunction

endpackage

// File: rtl/count_prescaler.sv
// ----------------------------------------------------------------------------
// count_prescaler
// Divides enabled cycles down to counter ticks: one tick per prescale+1
// enabled cycles.
//   clk      in  : system clock
//   rst      in  : synchronous active-high reset
//   en       in  : enable; pre_cnt only advances while high
//   restart  in  : discards the partial count (counter clear or load)
//   prescale in  : compare value, PRE_W bits
//   tick     out : combinational tick strobe consumed by the counter step
// ----------------------------------------------------------------------------
module count_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    // >= rather than == so that lowering prescale below the running count
    // produces a tick immediately instead of running the count all the way
    // around.
    assign tick = en && (pre_cnt >= prescale);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (restart) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/sync_updown_counter.sv
// ----------------------------------------------------------------------------
// sync_updown_counter
// Synchronous event/timebase counter over 0..MAX_VAL with direction, wrap or
// saturate at the bounds, parallel load, clear, prescaler, terminal-count
// pulse and sticky overflow flag. Every output is a flop on clk.
//   clk      in  : system clock
//   rst      in  : synchronous active-high reset
//   en       in  : count enable (gates the prescaler)
//   clr      in  : synchronous clear of q, prescaler, tc and ovf
//   load     in  : parallel load strobe (works with en low)
//   load_val in  : load value, clamped to MAX_VAL
//   up_dn    in  : 1 = up, 0 = down
//   sat      in  : 1 = saturate at the bounds, 0 = wrap
//   prescale in  : q advances once per prescale+1 enabled cycles
//   q        out : counter value
//   tc       out : one-cycle pulse after a tick that hit the bound
//   ovf      out : sticky bound-hit flag, cleared by rst or clr
// ----------------------------------------------------------------------------
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int PRE_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic             sat,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    generate
        if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
            $error("sync_updown_counter: WIDTH must be in 1..31");
        end
        if (MAX_VAL < 1 || MAX_VAL > (2**WIDTH) - 1) begin : g_bad_max
            $error("sync_updown_counter: MAX_VAL must be in 1..2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic             tick;
    logic             restart;
    logic             at_max;
    logic             at_zero;
    logic             hit;
    step_act_e        act;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_load;

    // A load also restarts the prescaler so the first period after a load is
    // a full one.
    assign restart = clr | load;

    count_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .restart  (restart),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        at_max  = (q == MAX_Q);
        at_zero = (q == '0);
        act     = step_action(up_dn, sat, at_max, at_zero);
        hit     = tick && is_boundary(up_dn, at_max, at_zero);

        q_step = q;
        case (act)
            ACT_INC:     q_step = q + WIDTH'(1);
            ACT_DEC:     q_step = q - WIDTH'(1);
            ACT_TO_ZERO: q_step = '0;
            ACT_TO_MAX:  q_step = MAX_Q;
            default:     q_step = q;
        endcase

        // Clamping on load keeps q inside 0..MAX_VAL, so the step logic
        // never has to handle an out-of-range value.
        q_load = (load_val > MAX_Q) ? MAX_Q : load_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (clr) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (load) begin
            q   <= q_load;
            tc  <= 1'b0;
        end else if (tick) begin
            q   <= q_step;
            tc  <= hit;
            if (hit) begin
                ovf <= 1'b1;
            end
        end else begin
            tc  <= 1'b0;
        end
    end

endmodule

// File: doc/sync_updown_counter.md
Name: sync_updown_counter

Overview:
- Parametrised synchronous counter; successor to the 4-bit ripple up counter.
- All flops on one clock; no derived clocks.
- Adds up/down direction, programmable modulus, parallel load, synchronous clear, wrap/saturate mode, a programmable prescaler, a terminal-count pulse and a sticky overflow flag.
- Used as a general event/timebase counter in the datapath and control blocks.

Parameters:
- WIDTH, 4: counter width in bits.
- MAX_VAL, 2**WIDTH-1: terminal value; count range is 0..MAX_VAL. Legal range is 1..2**WIDTH-1, enforced with an elaboration-time assertion.
- PRE_W, 8: prescaler compare width.

Ports:
- clk, in, 1: system clock; all state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: count enable; gates the prescaler.
- clr, in, 1: synchronous clear of q, prescaler and ovf.
- load, in, 1: parallel load strobe.
- load_val, in, WIDTH: value loaded into q.
- up_dn, in, 1: direction; 1 = up, 0 = down.
- sat, in, 1: boundary mode; 1 = saturate, 0 = wrap.
- prescale, in, PRE_W: q advances once per prescale+1 enabled cycles.
- q, out, WIDTH: counter value (registered).
- tc, out, 1: terminal-count pulse (registered, one cycle).
- ovf, out, 1: sticky boundary-hit flag (registered).

Behaviour:
- Reset: on a rising clk edge with rst=1, set q=0, tc=0, ovf=0, pre_cnt=0.
- Priority per edge: rst > clr > load > tick step > hold.
- clr: q=0, pre_cnt=0, ovf=0, tc=0.
- load: q = min(load_val, MAX_VAL), pre_cnt=0, tc=0; ovf is unchanged. load is honoured regardless of en.
- Prescaler:
  - Internal pre_cnt (PRE_W bits).
  - tick = en && (pre_cnt >= prescale).
  - On tick, pre_cnt <= 0. If en=1 and no tick, pre_cnt <= pre_cnt+1. If en=0, pre_cnt holds.
  - The >= compare guarantees a tick when prescale is lowered mid-count.
  - prescale=0 gives a tick on every enabled cycle.
- Step on tick:
  - up, q<MAX_VAL: q+1.
  - up, q==MAX_VAL: sat=0 gives q=0; sat=1 holds at MAX_VAL.
  - down, q>0: q-1.
  - down, q==0: sat=0 gives q=MAX_VAL; sat=1 holds at 0.
  - Out-of-range q cannot occur; loads are clamped.
- Boundary hit: a tick with (up && q==MAX_VAL) or (!up && q==0).
- tc: 1 for exactly the edge following a boundary hit, in both wrap and saturate modes. Otherwise 0. In saturate mode, repeated ticks at the bound re-pulse tc on each tick.
- ovf: set on a boundary hit; cleared only by rst or clr.
- Latency: q, tc and ovf all update on the same edge that samples tick. No combinational path from inputs to outputs.
- up_dn, sat and prescale are sampled each edge. A direction change applies to the next tick; there is no glitch or skipped count.
- Reset or clr mid-prescale discards the partial prescale count.

Decomposition:
- Shared package counter_pkg:
  - localparam direction encodings DIR_UP=1'b1 and DIR_DN=1'b0.
  - localparam mode encodings MODE_WRAP=1'b0 and MODE_SAT=1'b1.
- One sub-module, count_prescaler:
  - Parameter PRE_W.
  - Ports clk, rst, en, restart (clr|load), prescale; output tick.
  - Contains pre_cnt and the >= compare.
- The top module holds q, tc and ovf, plus the step/priority logic.

Test Plan:
- Reset hold: rst=1 for 3 cycles with en=1 -> q=0, tc=0, ovf=0; first enabled edge after release gives q=1 (prescale=0).
- Up wrap (WIDTH=4, MAX_VAL=9, sat=0, prescale=0, en=1): 10 edges -> q goes 1..9 then 0. tc=1 only on the edge q becomes 0; ovf=1 from then on.
- Down saturate (sat=1, up_dn=0, load_val=2): load, then 4 ticks -> q=1,0,0,0. tc pulses on ticks 3 and 4; ovf=1.
- Prescaler (prescale=3, en=1): q increments every 4th edge. Toggling en low for 2 cycles mid-period stretches that period to 6 edges. Lowering prescale from 3 to 0 while pre_cnt=2 gives a tick on the next edge.
- Load/clr priority: load_val=15 with MAX_VAL=9 -> q=9. Same edge clr=1 and load=1 -> q=0, ovf=0. load with en=0 still loads.
- Direction flip: counting up at q=5, set up_dn=0 -> the next tick gives q=4; no skipped or double count.
